// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO around a dual-port RAM. The RAM's
// registered read port doubles as the output register that presents the head word.

module dpram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              wclk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rclk,
   input  logic              rd,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge wclk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge rclk) begin
      if (rd) rdata <= mem[raddr];
   end
endmodule

module fifo_sync #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int AFULL_LVL  = (2**ADDR_W) - 4,
   parameter int AEMPTY_LVL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wr,
   output logic              full,
   output logic              almost_full,
   output logic              wr_err,
   output logic [DATA_W-1:0] rdata,
   input  logic              rd,
   output logic              empty,
   output logic              almost_empty,
   output logic              rd_err,
   output logic [ADDR_W:0]   count
);
   localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AFULL_LVL);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AEMPTY_LVL);

   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W:0]   count_nxt, ram_cnt;
   logic              ov, ov_nxt;
   logic              wr_acc, rd_acc, ram_rd;

   // Acceptance decisions, all from registered state ahead of the edge
   assign wr_acc  = wr && !full;
   assign rd_acc  = rd && ov;
   assign ram_cnt = count - {{ADDR_W{1'b0}}, ov};
   // Refill the output register when it is free or being popped this cycle
   assign ram_rd  = (ram_cnt != '0) && (!ov || rd_acc);
   assign ov_nxt  = ram_rd || (ov && !rd_acc);

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)
         count_nxt = count + 1'b1;
      else if (rd_acc && !wr_acc)
         count_nxt = count - 1'b1;
   end

   dpram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .wclk  (clk),
      .we    (wr_acc),
      .waddr (wptr),
      .wdata (wdata),
      .rclk  (clk),
      .rd    (ram_rd),
      .raddr (rptr),
      .rdata (rdata)
   );

   // Pointers, fill level and registered flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         ov           <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         wr_err       <= 1'b0;
         rd_err       <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (ram_rd) rptr <= rptr + 1'b1;
         count        <= count_nxt;
         ov           <= ov_nxt;
         empty        <= !ov_nxt;
         full         <= (count_nxt == DEPTH_C);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
         wr_err       <= wr && full;
         rd_err       <= rd && !ov;
      end
   end
endmodule
